// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: the fetch entry layout and the
// default instruction queue depth used by the fetch/decode boundary.
package rv_pkg;

   // Default number of fetch entries buffered between fetch and decode.
   localparam int IQ_DEPTH = 4;

   // One buffered fetch: the instruction's PC and its 32-bit word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
//
// Handshake: an entry moves on a clock edge only when its producer asserts
// valid and its consumer is ready in the same cycle. On the fetch side,
// "ready" is ~o_full, so fetch holds its PC while o_full is 1. On the decode
// side, o_valid/o_pc/o_inst present the head entry and i_ready consumes it.
// i_flush overrides both sides and empties the queue at the next edge.
// All outputs come from registered state, so there is no input-to-output path.
module inst_queue
   import rv_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic [31:0]              i_pc,
   input  logic [31:0]              i_inst,
   input  logic                     i_flush,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [31:0]              o_pc,
   output logic [31:0]              o_inst,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic [PW-1:0]   wr_ptr_nxt;
   logic [PW-1:0]   rd_ptr_nxt;
   logic [CW-1:0]   count_nxt;
   logic            push;
   logic            pop;

   // Status flags are derived from the registered occupancy only.
   assign o_valid = (count != '0);
   assign o_full  = (count == CW'(DEPTH));
   assign o_count = count;

   // A full queue refuses fetch even when decode drains the head this cycle.
   assign push = i_valid & ~o_full & ~i_flush;
   assign pop  = o_valid & i_ready & ~i_flush;

   // Head entry; meaningless while o_valid is 0.
   assign o_pc   = mem[rd_ptr].pc;
   assign o_inst = mem[rd_ptr].inst;

   // Next pointer and occupancy; flush dominates any push or pop.
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      if (i_flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count_nxt = count + CW'(1);
         end else if (pop && !push) begin
            count_nxt = count - CW'(1);
         end
      end
   end

   // Pointer and occupancy registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
      end
   end

   // Entry storage; contents are only read behind a valid count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: i_pc, inst: i_inst};
      end
   end

endmodule
